// File: rtl/mod_matrix_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// mod_matrix_pkg : shared widths, frame lengths and scheduler states
// Revision 1.0
// ------------------------------------------------------------------
package mod_matrix_pkg;

  localparam int DEF_VOICES    = 8;
  localparam int DEF_V_OSC     = 4;
  localparam int DEF_O_ENVS    = 2;
  localparam int DEF_V_WIDTH   = 3;
  localparam int DEF_O_WIDTH   = 2;
  localparam int DEF_OE_WIDTH  = 1;
  localparam int DEF_DLY_DEPTH = DEF_V_OSC * DEF_VOICES - 1;

  localparam int FRAME_LEN = DEF_VOICES * DEF_V_OSC * DEF_O_ENVS;
  localparam int DRAIN_LEN = DEF_DLY_DEPTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    SWAP  = 2'd3
  } sched_state_t;

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/slot_delay_line.sv
`default_nettype none
// ------------------------------------------------------------------
// slot_delay_line : WIDTH x DEPTH tap shift register, sync reset
// Revision 1.0
// ------------------------------------------------------------------
module slot_delay_line #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 31
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [WIDTH-1:0]            din,
  output logic [DEPTH-1:0][WIDTH-1:0] taps
);

  generate
    if (DEPTH > 1) begin : g_chain
      always_ff @(posedge clk) begin
        if (reset) taps <= '0;
        else       taps <= {taps[DEPTH-2:0], din};
      end
    end else begin : g_single
      always_ff @(posedge clk) begin
        if (reset) taps <= '0;
        else       taps <= din;
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/mod_matrix_scheduler.sv
`default_nettype none
// ------------------------------------------------------------------
// mod_matrix_scheduler : frame slot sequencer with between-frame bank swap
// Revision 1.0
// ------------------------------------------------------------------
module mod_matrix_scheduler
  import mod_matrix_pkg::*;
#(
  parameter int VOICES    = DEF_VOICES,
  parameter int V_OSC     = DEF_V_OSC,
  parameter int O_ENVS    = DEF_O_ENVS,
  parameter int V_WIDTH   = DEF_V_WIDTH,
  parameter int O_WIDTH   = DEF_O_WIDTH,
  parameter int OE_WIDTH  = DEF_OE_WIDTH,
  parameter int DLY_DEPTH = V_OSC * VOICES - 1
) (
  input  logic                            sCLK_XVXENVS,
  input  logic                            reset,
  input  logic                            run_enable,
  input  logic                            sample_tick,
  input  logic                            mat_upd_req,
  output logic                            mat_upd_ack,
  output logic                            mat_bank_sel,
  output logic                            busy,
  output logic                            frame_done,
  output logic                            overrun,
  output logic [OE_WIDTH-1:0]             e_cnt,
  output logic [O_WIDTH-1:0]              ox,
  output logic [V_WIDTH-1:0]              vx,
  output logic [V_OSC*O_ENVS:0]           sh_osc_reg,
  output logic [V_OSC+2:0]                sh_voice_reg,
  output logic [DLY_DEPTH-1:0][O_WIDTH-1:0] ox_dly,
  output logic [DLY_DEPTH-1:0][V_WIDTH-1:0] vx_dly
);

  localparam int DRAIN_CYC = DLY_DEPTH + 1;
  localparam int DC_W      = cnt_width(DRAIN_CYC);
  localparam int SHO_W     = V_OSC * O_ENVS + 1;
  localparam int SHV_W     = V_OSC + 3;

  localparam logic [OE_WIDTH-1:0] E_LAST = OE_WIDTH'(O_ENVS - 1);
  localparam logic [O_WIDTH-1:0]  O_LAST = O_WIDTH'(V_OSC - 1);
  localparam logic [V_WIDTH-1:0]  V_LAST = V_WIDTH'(VOICES - 1);
  localparam logic [DC_W-1:0]     D_LAST = DC_W'(DRAIN_CYC - 1);

  sched_state_t    state;
  logic [DC_W-1:0] drain_cnt;
  logic            e_wrap;
  logic            o_wrap;
  logic            last_slot;
  logic            osc_strobe;
  logic            voice_strobe;

  // Wraps compare against the parameter, so non-power-of-2 counts work
  assign e_wrap       = (e_cnt == E_LAST);
  assign o_wrap       = (ox == O_LAST);
  assign last_slot    = e_wrap && o_wrap && (vx == V_LAST);
  assign osc_strobe   = (state == RUN) && e_wrap;
  assign voice_strobe = osc_strobe && o_wrap;

  always_ff @(posedge sCLK_XVXENVS) begin
    if (reset) begin
      state        <= IDLE;
      drain_cnt    <= '0;
      e_cnt        <= '0;
      ox           <= '0;
      vx           <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      mat_upd_ack  <= 1'b0;
      mat_bank_sel <= 1'b0;
      overrun      <= 1'b0;
      sh_osc_reg   <= '0;
      sh_voice_reg <= '0;
    end else begin
      frame_done   <= 1'b0;
      mat_upd_ack  <= 1'b0;
      sh_osc_reg   <= {sh_osc_reg[SHO_W-2:0], osc_strobe};
      sh_voice_reg <= {sh_voice_reg[SHV_W-2:0], voice_strobe};

      if (sample_tick && (state != IDLE)) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (sample_tick && run_enable) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (last_slot) begin
            state     <= DRAIN;
            drain_cnt <= '0;
            e_cnt     <= '0;
            ox        <= '0;
            vx        <= '0;
          end else if (e_wrap) begin
            e_cnt <= '0;
            if (o_wrap) begin
              ox <= '0;
              vx <= vx + V_WIDTH'(1);
            end else begin
              ox <= ox + O_WIDTH'(1);
            end
          end else begin
            e_cnt <= e_cnt + OE_WIDTH'(1);
          end
        end
        DRAIN: begin
          // Drain lets the final slot reach the deepest tap before any swap
          if (drain_cnt == D_LAST) begin
            frame_done <= 1'b1;
            if (mat_upd_req) begin
              state <= SWAP;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            drain_cnt <= drain_cnt + DC_W'(1);
          end
        end
        SWAP: begin
          state        <= IDLE;
          busy         <= 1'b0;
          mat_upd_ack  <= 1'b1;
          mat_bank_sel <= ~mat_bank_sel;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  slot_delay_line #(
    .WIDTH (O_WIDTH),
    .DEPTH (DLY_DEPTH)
  ) u_ox_dly (
    .clk   (sCLK_XVXENVS),
    .reset (reset),
    .din   (ox),
    .taps  (ox_dly)
  );

  slot_delay_line #(
    .WIDTH (V_WIDTH),
    .DEPTH (DLY_DEPTH)
  ) u_vx_dly (
    .clk   (sCLK_XVXENVS),
    .reset (reset),
    .din   (vx),
    .taps  (vx_dly)
  );

endmodule
`default_nettype wire
